// File: rtl/ahblite_slave_mux_if.sv
// AHB-Lite response-mux bus bundle: master-side address-phase controls,
// the four slave ports and the muxed response back to the master.
// The slave modport is the mux's own view; the master modport drives it.
interface ahblite_slave_mux_if;
  // Address-phase controls seen by the decoder and by the mux
  logic        HSEL_M;
  logic [1:0]  HTRANS;
  logic        HREADY;

  // Decoder selects
  logic        P0_HSEL;
  logic        P1_HSEL;
  logic        P2_HSEL;
  logic        P3_HSEL;

  // Slave responses
  logic        P0_HREADYOUT;
  logic        P1_HREADYOUT;
  logic        P2_HREADYOUT;
  logic        P3_HREADYOUT;
  logic [31:0] P0_HRDATA;
  logic [31:0] P1_HRDATA;
  logic [31:0] P2_HRDATA;
  logic [31:0] P3_HRDATA;
  logic        P0_HRESP;
  logic        P1_HRESP;
  logic        P2_HRESP;
  logic        P3_HRESP;

  // Muxed response to the master
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        TIMEOUT_IRQ;

  modport slave (
    input  HSEL_M, HTRANS, HREADY,
    input  P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL,
    input  P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
    input  P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
    input  P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP,
    output HREADYOUT, HRDATA, HRESP, TIMEOUT_IRQ
  );

  modport master (
    output HSEL_M, HTRANS, HREADY,
    output P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL,
    output P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
    output P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
    output P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP,
    input  HREADYOUT, HRDATA, HRESP, TIMEOUT_IRQ
  );
endinterface

// File: rtl/ahblite_slave_mux.sv
// ahblite_slave_mux: data-phase response multiplexer for the four-port
// AHB-Lite decoder (P0..P3 at 0xC000_0000..0xC003_FFFF), with a built-in
// default slave that answers unmapped NONSEQ/SEQ transfers with a
// two-cycle ERROR.
// Optional feature macro: AHBLITE_SLAVE_MUX_TIMEOUT_EN adds a stalled-slave
// watchdog that aborts the data phase into the ERROR sequence and raises a
// sticky TIMEOUT_IRQ.
module ahblite_slave_mux #(
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input logic                HCLK,
  input logic                HRESET,
  ahblite_slave_mux_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [3:0]  sel_reg;
  logic [3:0]  sel_next;

  logic [3:0]  p_hsel;
  logic [3:0]  p_hreadyout;
  logic [3:0]  p_hresp;
  logic [31:0] p_hrdata [4];

  logic [3:0]  grant;
  logic [31:0] rdata_term [4];
  logic        slv_ready;
  logic        slv_resp;
  logic [31:0] slv_rdata;

  logic        accept;
  logic        trans_active;
  logic        unmapped_now;
  logic        stalled;
  logic        timeout_abort;

  logic        hreadyout_c;
  logic        hresp_c;
  logic [31:0] hrdata_c;

  // Gather the per-port signals into vectors so the mux can be generated.
  assign p_hsel      = {bus.P3_HSEL, bus.P2_HSEL, bus.P1_HSEL, bus.P0_HSEL};
  assign p_hreadyout = {bus.P3_HREADYOUT, bus.P2_HREADYOUT,
                        bus.P1_HREADYOUT, bus.P0_HREADYOUT};
  assign p_hresp     = {bus.P3_HRESP, bus.P2_HRESP, bus.P1_HRESP, bus.P0_HRESP};
  assign p_hrdata[0] = bus.P0_HRDATA;
  assign p_hrdata[1] = bus.P1_HRDATA;
  assign p_hrdata[2] = bus.P2_HRDATA;
  assign p_hrdata[3] = bus.P3_HRDATA;

  // An address phase is taken whenever the bus is ready.
  assign accept       = bus.HREADY;
  // Only NONSEQ and SEQ carry data; IDLE and BUSY get a zero-wait OKAY.
  assign trans_active = (bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11);
  // The registered "unmapped" flag is the ERR1 state itself: it is entered on
  // exactly the edge where this term is captured.
  assign unmapped_now = bus.HSEL_M & trans_active & ~(|p_hsel);

  // Fixed-priority grant from the registered select: lowest port wins, so a
  // decoder that ever drives two selects still yields a single source.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_port
      if (gi == 0) begin : g_top
        assign grant[gi] = sel_reg[gi];
      end else begin : g_lower
        assign grant[gi] = sel_reg[gi] & ~(|sel_reg[gi-1:0]);
      end
      assign rdata_term[gi] = grant[gi] ? p_hrdata[gi] : 32'h0000_0000;
    end
  endgenerate

  // OR together the one-hot gated read-data terms.
  always_comb begin
    slv_rdata = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      slv_rdata = slv_rdata | rdata_term[i];
    end
  end

  assign slv_ready = |(grant & p_hreadyout);
  assign slv_resp  = |(grant & p_hresp);
  // A selected slave holding HREADYOUT low is stalling the bus.
  assign stalled   = (|sel_reg) & ~slv_ready;

  // Next-state and next-select for the default slave and the select register.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    if (accept) begin
      sel_next = p_hsel;
    end
    case (state_reg)
      ST_IDLE: begin
        if (accept && unmapped_now) begin
          state_next = ST_ERR1;
        end
      end
      ST_ERR1: begin
        state_next = ST_ERR2;
      end
      ST_ERR2: begin
        if (accept) begin
          state_next = unmapped_now ? ST_ERR1 : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    // A watchdog abort drops the stuck slave and reuses the ERROR sequence.
    if (timeout_abort) begin
      sel_next   = 4'b0000;
      state_next = ST_ERR1;
    end
  end

  // State and select registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg <= ST_IDLE;
      sel_reg   <= 4'b0000;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
    end
  end

  // Data-phase response: default slave states first, then the granted port,
  // otherwise a zero-wait OKAY.
  always_comb begin
    hreadyout_c = 1'b1;
    hresp_c     = 1'b0;
    hrdata_c    = ERR_RDATA;
    case (state_reg)
      ST_ERR1: begin
        hreadyout_c = 1'b0;
        hresp_c     = 1'b1;
      end
      ST_ERR2: begin
        hresp_c = 1'b1;
      end
      default: begin
        if (|sel_reg) begin
          hreadyout_c = slv_ready;
          hresp_c     = slv_resp;
          hrdata_c    = slv_rdata;
        end
      end
    endcase
  end

  assign bus.HREADYOUT = hreadyout_c;
  assign bus.HRESP     = hresp_c;
  assign bus.HRDATA    = hrdata_c;

`ifdef AHBLITE_SLAVE_MUX_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] stall_cnt_reg;
  logic        timeout_irq_reg;

  // Abort on the stalled cycle that finds the count at its last value.
  assign timeout_abort = stalled && (stall_cnt_reg == TIMEOUT_LAST);

  // Consecutive-stall counter and sticky timeout flag.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      stall_cnt_reg   <= 16'd0;
      timeout_irq_reg <= 1'b0;
    end else begin
      if (timeout_abort || !stalled) begin
        stall_cnt_reg <= 16'd0;
      end else begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
      if (timeout_abort) begin
        timeout_irq_reg <= 1'b1;
      end
    end
  end

  assign bus.TIMEOUT_IRQ = timeout_irq_reg;
`else
  // No watchdog: a stalled slave holds the bus for as long as it likes.
  assign timeout_abort   = 1'b0;
  // Folds to constant 0 for every legal TIMEOUT_CYCLES.
  assign bus.TIMEOUT_IRQ = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: doc/ahblite_slave_mux.md
Name: ahblite_slave_mux

Overview:
- Data-phase response multiplexer directly downstream of the four-port AHB-Lite address decoder.
- Registers the decoder's per-port HSEL outputs in the address phase. Steers the selected slave's HREADYOUT/HRDATA/HRESP back to the master in the data phase.
- Contains a built-in default slave. It answers unmapped transfers (master-level select asserted, no port selected) with a two-cycle AHB ERROR response.
- Sits between the bus master's HREADY/HRDATA/HRESP inputs and slaves P0..P3, which are mapped at 0xC000_0000 to 0xC003_FFFF.

Parameters:
- ERR_RDATA, 32'h0000_0000, HRDATA value driven during default-slave ERROR cycles and idle data phases.
- TIMEOUT_CYCLES, 256, number of consecutive stalled data-phase cycles before a timeout abort (only with the optional feature; legal range 2..65535).

Ports:
- HCLK  input  1  bus clock; all state updates on rising edge
- HRESET  input  1  synchronous, active-high reset
- HSEL_M  input  1  master-level select, same signal fed to the decoder
- HTRANS  input  2  address-phase transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HREADY  input  1  bus-wide ready; normally wired from this block's HREADYOUT
- P0_HSEL..P3_HSEL  input  1 each  decoder outputs for ports 0..3
- P0_HREADYOUT..P3_HREADYOUT  input  1 each  slave ready outputs
- P0_HRDATA..P3_HRDATA  input  32 each  slave read data
- P0_HRESP..P3_HRESP  input  1 each  slave response (0 OKAY, 1 ERROR)
- HREADYOUT  output  1  muxed ready to master
- HRDATA  output  32  muxed read data to master
- HRESP  output  1  muxed response to master
- TIMEOUT_IRQ  output  1  sticky timeout flag; tied 0 without the optional feature

Behaviour:
- Address phase is accepted on a rising edge where HREADY=1. When HREADY=0, all address-phase registers hold.
- On accept, sel_q[3:0] <= {P3_HSEL,P2_HSEL,P1_HSEL,P0_HSEL}.
- Also on accept, unmapped_q <= HSEL_M & HTRANS[1] & ~|{P3..P0_HSEL}.
- Data-phase output when sel_q is nonzero: the lowest set bit i wins (P0 has highest priority if the decoder ever drives more than one). Outputs are HREADYOUT=Pi_HREADYOUT, HRDATA=Pi_HRDATA, HRESP=Pi_HRESP. All paths are combinational from slave outputs.
- Data-phase output when sel_q=0 and the FSM is IDLE: HREADYOUT=1, HRESP=0, HRDATA=ERR_RDATA (zero-wait OKAY).
- IDLE or BUSY transfers to unmapped space, and transfers with HSEL_M=0, get a zero-wait OKAY response.
- Default-slave FSM has three states: IDLE, ERR1, ERR2.
  - IDLE -> ERR1 on an accepted unmapped transfer.
  - ERR1: HREADYOUT=0, HRESP=1, HRDATA=ERR_RDATA. Always -> ERR2 next cycle.
  - ERR2: HREADYOUT=1, HRESP=1, HRDATA=ERR_RDATA. Because HREADY=1 here, a new address phase is accepted this cycle.
  - ERR2 -> ERR1 if that new transfer is unmapped; otherwise -> IDLE, and sel_q takes the new select.
  - Back-to-back unmapped transfers therefore produce ERR1, ERR2, ERR1, ERR2 with no gap.
- In ERR1 and ERR2, sel_q is 0 and the slave inputs are ignored.
- A master-side abort is allowed: the master may drive HTRANS=IDLE in the ERR2 address phase. No special handling is needed.
- Reset values: sel_q=0, unmapped_q=0, FSM=IDLE, HREADYOUT=1, HRESP=0, HRDATA=ERR_RDATA, TIMEOUT_IRQ=0.
- Reset asserted mid-transfer (including ERR1 or a stalled slave) returns to the reset state at the next edge. Outputs show the reset values in the following cycle. The pending transfer is dropped.
- No combinational path exists from HTRANS, HSEL_M or Px_HSEL to any output.

Optional Feature:
- Macro: AHBLITE_SLAVE_MUX_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments each cycle that sel_q is nonzero and the selected HREADYOUT=0.
  - The counter clears on the selected HREADYOUT=1 or on reset.
  - When the count reaches TIMEOUT_CYCLES-1 while still stalled, the next edge does three things:
    - clears sel_q and the counter;
    - forces the FSM to ERR1, giving the normal two-cycle ERROR to the master;
    - sets TIMEOUT_IRQ=1.
  - TIMEOUT_IRQ is sticky; only HRESET clears it.
  - The stuck slave's later outputs are ignored.
- Not defined:
  - No counter is instantiated; TIMEOUT_IRQ is constant 0.
  - A stalled slave stalls the bus indefinitely.

Test Plan:
- Reset: hold HRESET high for 3 cycles, then release -> HREADYOUT=1, HRESP=0, HRDATA=ERR_RDATA, TIMEOUT_IRQ=0 during and after reset.
- Mapped read: P1_HSEL=1, HTRANS=NONSEQ accepted; P1_HRDATA=32'h1234_5678 with P1_HREADYOUT low for 2 cycles -> HREADYOUT low for exactly 2 cycles, then HRDATA=32'h1234_5678, HRESP=0. Back-to-back P2 access: its data appears the cycle after.
- Unmapped: HSEL_M=1, HTRANS=NONSEQ, all Px_HSEL=0 -> cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1, then OKAY. Repeat with HTRANS=IDLE -> zero-wait OKAY, no ERROR.
- Back-to-back: unmapped, unmapped, P0 (P0_HRDATA=32'hA5A5_A5A5) -> ERR1, ERR2, ERR1, ERR2, then 32'hA5A5_A5A5 OKAY.
- Reset mid-ERR1, and reset during a P3 stall -> outputs return to reset values the next cycle; FSM is IDLE.
- With AHBLITE_SLAVE_MUX_TIMEOUT_EN and TIMEOUT_CYCLES=8: P0_HREADYOUT held 0 -> HREADYOUT low 8 cycles, then ERR1/ERR2; TIMEOUT_IRQ=1 and stays 1 until HRESET.
